// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard/stall/flush controller with MDU busy tracking
// Optional feature macro: STALL_PERF_CNT_EN (adds 32-bit saturating stall cycle counter output stall_cnt)
module pipe_hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs_addr,
  input  logic [4:0] d_rt_addr,
  input  logic       d_rs_use,
  input  logic       d_rt_use,
  input  logic [4:0] e_wr_addr,
  input  logic       e_wr_late,
  input  logic       d_is_md,
  input  logic       e_md_start,
  input  logic       e_md_div,
  input  logic       exc_req,
  output logic       f_en,
  output logic       d_en,
  output logic       e_en,
  output logic       d_clr,
  output logic       e_clr,
  output logic       m_clr,
  output logic       w_clr,
  output logic       stall,
  output logic       md_busy,
  output logic       md_start_ok,
  output logic       req,
  output logic [1:0] state
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_MDWAIT = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  localparam logic [3:0] MD_MULT_CYC = 4'd5;
  localparam logic [3:0] MD_DIV_CYC  = 4'd10;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_md_cnt;
  logic [3:0] w_md_cnt_nxt;
  logic       w_req;
  logic       w_stall_ld;
  logic       w_stall_md;
  logic       w_rs_hit;
  logic       w_rt_hit;

  // Exception request is suppressed while the block itself is in reset.
  assign w_req       = exc_req & ~reset;
  assign req         = w_req;
  assign md_busy     = (r_md_cnt != 4'd0);
  // A killed instruction must not start the MDU.
  assign md_start_ok = e_md_start & ~w_req;
  assign state       = r_state;

  // $0 is hardwired to zero, so it never creates a load-use dependency.
  assign w_rs_hit   = d_rs_use & (d_rs_addr != 5'd0) & (d_rs_addr == e_wr_addr);
  assign w_rt_hit   = d_rt_use & (d_rt_addr != 5'd0) & (d_rt_addr == e_wr_addr);
  assign w_stall_ld = (w_rs_hit | w_rt_hit) & e_wr_late;
  assign w_stall_md = d_is_md & (md_busy | e_md_start);

  // MDU countdown: a new accepted op always reloads, otherwise count down to zero.
  always_comb begin
    w_md_cnt_nxt = r_md_cnt;
    if (md_start_ok) begin
      w_md_cnt_nxt = e_md_div ? MD_DIV_CYC : MD_MULT_CYC;
    end else if (r_md_cnt != 4'd0) begin
      w_md_cnt_nxt = r_md_cnt - 4'd1;
    end
  end

  // MDU counter register; exceptions do not abort an in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_md_cnt <= 4'd0;
    end else begin
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: exceptions always (re)enter FLUSH; otherwise track MDU busy.
  always_comb begin
    w_state_nxt = ST_RUN;
    if (w_req) begin
      w_state_nxt = ST_FLUSH;
    end else if (w_md_cnt_nxt != 4'd0) begin
      w_state_nxt = ST_MDWAIT;
    end
  end

  // Enables/clears, priority: reset > exception > flush cycle > stall > run.
  always_comb begin
    f_en  = 1'b1;
    d_en  = 1'b1;
    e_en  = 1'b1;
    d_clr = 1'b0;
    e_clr = 1'b0;
    m_clr = 1'b0;
    w_clr = 1'b0;
    stall = 1'b0;
    if (reset) begin
      f_en  = 1'b0;
      d_en  = 1'b0;
      e_en  = 1'b0;
      d_clr = 1'b1;
      e_clr = 1'b1;
      m_clr = 1'b1;
      w_clr = 1'b1;
    end else if (w_req) begin
      d_clr = 1'b1;
      e_clr = 1'b1;
      m_clr = 1'b1;
    end else if (r_state == ST_FLUSH) begin
      // Kill the wrong-path instruction fetched during the request cycle.
      d_clr = 1'b1;
      e_clr = 1'b1;
    end else if (w_stall_ld | w_stall_md) begin
      f_en  = 1'b0;
      d_en  = 1'b0;
      e_clr = 1'b1;
      stall = 1'b1;
    end
  end

`ifdef STALL_PERF_CNT_EN
  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'd0;
    end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs_addr, d_rt_addr, e_wr_addr;
  logic       d_rs_use, d_rt_use, e_wr_late;
  logic       d_is_md, e_md_start, e_md_div, exc_req;
  logic       f_en, d_en, e_en, d_clr, e_clr, m_clr, w_clr;
  logic       stall, md_busy, md_start_ok, req;
  logic [1:0] state;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
    .d_rs_use(d_rs_use), .d_rt_use(d_rt_use),
    .e_wr_addr(e_wr_addr), .e_wr_late(e_wr_late),
    .d_is_md(d_is_md), .e_md_start(e_md_start), .e_md_div(e_md_div),
    .exc_req(exc_req),
    .f_en(f_en), .d_en(d_en), .e_en(e_en),
    .d_clr(d_clr), .e_clr(e_clr), .m_clr(m_clr), .w_clr(w_clr),
    .stall(stall), .md_busy(md_busy), .md_start_ok(md_start_ok), .req(req),
    .state(state)
`ifdef STALL_PERF_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    d_rs_addr = 5'd0; d_rt_addr = 5'd0; e_wr_addr = 5'd0;
    d_rs_use = 1'b0; d_rt_use = 1'b0; e_wr_late = 1'b0;
    d_is_md = 1'b0; e_md_start = 1'b0; e_md_div = 1'b0; exc_req = 1'b0;
  endtask

  // Advance one clock; inputs change and outputs are sampled mid-low-phase.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic set_ld_stall();
    e_wr_addr = 5'd5; e_wr_late = 1'b1; d_rs_addr = 5'd5; d_rs_use = 1'b1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(negedge clk); #1;
    // Outputs during reset cycle, even with an exception and load hazard present
    set_ld_stall();
    exc_req = 1'b1;
    chk("rst_f_en", f_en, 0);
    chk("rst_e_en", e_en, 0);
    chk("rst_clrs", {d_clr, e_clr, m_clr, w_clr}, 4'b1111);
    chk("rst_stall", stall, 0);
    chk("rst_req", req, 0);
    tick();
    idle();
    chk("rst_state", state, 0);
    chk("rst_busy", md_busy, 0);
    reset = 1'b0;
    #1;
    chk("run_en", {f_en, d_en, e_en}, 3'b111);
    chk("run_clrs", {d_clr, e_clr, m_clr, w_clr}, 4'b0000);

    // Load-use on rs
    set_ld_stall();
    #1;
    chk("ld_stall", stall, 1);
    chk("ld_en", {f_en, d_en, e_en}, 3'b001);
    chk("ld_clrs", {d_clr, e_clr, m_clr, w_clr}, 4'b0100);
    // $0 never stalls
    e_wr_addr = 5'd0; d_rs_addr = 5'd0;
    #1;
    chk("ld_r0", stall, 0);
    // rt path, then without late result
    idle();
    e_wr_addr = 5'd7; e_wr_late = 1'b1; d_rt_addr = 5'd7; d_rt_use = 1'b1;
    #1;
    chk("ld_rt", stall, 1);
    d_rt_use = 1'b0;
    #1;
    chk("ld_rt_nouse", stall, 0);
    d_rt_use = 1'b1; e_wr_late = 1'b0;
    #1;
    chk("ld_not_late", stall, 0);
    idle();

    // Divide: 10 busy cycles with d_is_md stalled throughout
    e_md_start = 1'b1; e_md_div = 1'b1;
    #1;
    chk("div_ok", md_start_ok, 1);
    chk("div_busy0", md_busy, 0);
    tick();
    idle();
    d_is_md = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("div_busy", md_busy, 1);
      chk("div_stall", stall, 1);
      chk("div_state", state, 1);
      tick();
    end
    chk("div_done_busy", md_busy, 0);
    chk("div_done_stall", stall, 0);
    chk("div_done_state", state, 0);
    idle();

    // Exception coincident with load stall
    set_ld_stall();
    exc_req = 1'b1;
    #1;
    chk("exc_stall", stall, 0);
    chk("exc_req", req, 1);
    chk("exc_clrs", {d_clr, e_clr, m_clr, w_clr}, 4'b1110);
    chk("exc_f_en", f_en, 1);
    tick();
    exc_req = 1'b0;
    #1;
    chk("fl_state", state, 2);
    chk("fl_clrs", {d_clr, e_clr, m_clr, w_clr}, 4'b1100);
    chk("fl_f_en", f_en, 1);
    chk("fl_stall", stall, 0);
    // Exception during FLUSH restarts it
    exc_req = 1'b1;
    tick();
    exc_req = 1'b0;
    idle();
    chk("fl_restart", state, 2);
    tick();
    chk("fl_exit", state, 0);

    // Exception coincident with MDU start
    e_md_start = 1'b1; exc_req = 1'b1;
    #1;
    chk("mdx_ok", md_start_ok, 0);
    tick();
    idle();
    chk("mdx_busy", md_busy, 0);
    chk("mdx_state", state, 2);
    tick();

    // New op while busy reloads (div then mult after 2 cycles)
    e_md_start = 1'b1; e_md_div = 1'b1;
    tick();
    idle();
    tick();
    e_md_start = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      chk("reload_busy", md_busy, 1);
      tick();
    end
    chk("reload_done", md_busy, 0);

    // Exception during MDU op: FLUSH then back to MDWAIT, counter keeps running
    e_md_start = 1'b1;
    tick();
    idle();
    exc_req = 1'b1;
    tick();
    exc_req = 1'b0;
    chk("mdfl_state", state, 2);
    chk("mdfl_busy", md_busy, 1);
    tick();
    chk("mdfl_back", state, 1);
    tick(); tick();
    chk("mdfl_busy_end", md_busy, 1);
    tick();
    chk("mdfl_idle", md_busy, 0);
    chk("mdfl_run", state, 0);

    // Reset three cycles into a mult
    e_md_start = 1'b1;
    tick();
    idle();
    tick(); tick();
    chk("mrst_busy_pre", md_busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mrst_busy", md_busy, 0);
    chk("mrst_state", state, 0);
    chk("mrst_en", {f_en, d_en, e_en}, 3'b111);

`ifdef STALL_PERF_CNT_EN
    chk("pc_zero", stall_cnt, 0);
    set_ld_stall();
    for (int i = 0; i < 7; i++) tick();
    idle();
    chk("pc_seven", stall_cnt, 7);
    tick(); tick();
    chk("pc_hold", stall_cnt, 7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("pc_reset", stall_cnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
